// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges d-cache stall, load-use and taken-branch into PC/IF/ID/EX controls.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dcache_stall_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [REG_W-1:0] ID_EX_Rt_i,
  input  logic [REG_W-1:0] IF_ID_Rs_i,
  input  logic [REG_W-1:0] IF_ID_Rt_i,
  input  logic             branch_taken_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_STALL = 2'd1,
    RELEASE   = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              err_reg;
  logic              load_use;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = RUN;
    case (state_reg)
      RUN:       state_next = dcache_stall_i ? MEM_STALL : RUN;
      MEM_STALL: state_next = dcache_stall_i ? MEM_STALL : RELEASE;
      RELEASE:   state_next = dcache_stall_i ? MEM_STALL : RUN;
      default:   state_next = RUN;
    endcase
  end

  // The stall is never forcibly released; the timeout only raises a sticky flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      if (state_reg != MEM_STALL && state_next == MEM_STALL) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == MEM_STALL && dcache_stall_i && wait_cnt_reg != WAIT_MAX) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
      if (wait_cnt_reg == WAIT_MAX) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_o = err_reg;

  assign load_use = ID_EX_MemRead_i && (ID_EX_Rt_i != '0) &&
                    ((ID_EX_Rt_i == IF_ID_Rs_i) || (ID_EX_Rt_i == IF_ID_Rt_i));

  always_comb begin
    PC_Write_o     = 1'b1;
    IF_ID_Write_o  = 1'b1;
    IF_Flush_o     = 1'b0;
    ID_EX_Bubble_o = 1'b0;
    stall_o        = 1'b0;
    if (rst_i) begin
      stall_o        = 1'b1;
      PC_Write_o     = 1'b0;
      IF_ID_Write_o  = 1'b0;
      ID_EX_Bubble_o = 1'b1;
    end else if (state_reg == MEM_STALL || dcache_stall_i) begin
      stall_o       = 1'b1;
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
    end else if (load_use) begin
      PC_Write_o     = 1'b0;
      IF_ID_Write_o  = 1'b0;
      ID_EX_Bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IF_Flush_o = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(stall_o);
      flush_cnt_reg <= flush_cnt_reg + CNT_W'(IF_Flush_o);
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model queues expected controls per cycle.
module tb_pipeline_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dcache_stall;
  logic        mem_read;
  logic [4:0]  ex_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        id_ex_bubble;
  logic        stall;
  logic        err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  pipeline_ctrl #(.REG_W(5), .TIMEOUT_CYC(TO), .CNT_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .dcache_stall_i  (dcache_stall),
    .ID_EX_MemRead_i (mem_read),
    .ID_EX_Rt_i      (ex_rt),
    .IF_ID_Rs_i      (id_rs),
    .IF_ID_Rt_i      (id_rt),
    .branch_taken_i  (branch_taken),
    .PC_Write_o      (pc_write),
    .IF_ID_Write_o   (if_id_write),
    .IF_Flush_o      (if_flush),
    .ID_EX_Bubble_o  (id_ex_bubble),
    .stall_o         (stall),
    .err_o           (err),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc;
    logic        ifid;
    logic        flush;
    logic        bub;
    logic        stall;
    logic        err;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;
  int   step_no         = 0;

  // Reference model: 0=RUN 1=MEM_STALL 2=RELEASE
  int          m_state = 0;
  int          m_wait  = 0;
  logic        m_err   = 1'b0;
  logic [31:0] m_scnt  = '0;
  logic [31:0] m_fcnt  = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL step %0d %s got=%0h exp=%0h", step_no, tag, got, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle of inputs and checks mid-cycle.
  task automatic step(input logic r, input logic d, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br);
    exp_t e;
    exp_t g;
    logic lu;
    rst = r; dcache_stall = d; mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    branch_taken = br;
    if (r) begin
      m_state = 0; m_wait = 0; m_err = 1'b0; m_scnt = '0; m_fcnt = '0;
    end
    lu = mr && (ert != 5'd0) && (ert == rs || ert == rt);
    e.pc = 1'b1; e.ifid = 1'b1; e.flush = 1'b0; e.bub = 1'b0; e.stall = 1'b0;
    if (r) begin
      e.stall = 1'b1; e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
    end else if (m_state == 1 || d) begin
      e.stall = 1'b1; e.pc = 1'b0; e.ifid = 1'b0;
    end else if (lu) begin
      e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b1;
    end else if (br) begin
      e.flush = 1'b1;
    end
    e.err = m_err;
`ifdef PIPE_PERF_CNT_EN
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
`else
    e.scnt = '0;
    e.fcnt = '0;
`endif
    q.push_back(e);
    #3;
    g = q.pop_front();
    check_val("pc_write", {31'd0, pc_write}, {31'd0, g.pc});
    check_val("if_id_write", {31'd0, if_id_write}, {31'd0, g.ifid});
    check_val("if_flush", {31'd0, if_flush}, {31'd0, g.flush});
    check_val("bubble", {31'd0, id_ex_bubble}, {31'd0, g.bub});
    check_val("stall", {31'd0, stall}, {31'd0, g.stall});
    check_val("err", {31'd0, err}, {31'd0, g.err});
    check_val("stall_cnt", stall_cnt, g.scnt);
    check_val("flush_cnt", flush_cnt, g.fcnt);
    $display("step %0d rst=%b dst=%b mr=%b rt=%0d rs=%0d/%0d br=%b -> pc=%b ifid=%b fl=%b bub=%b st=%b err=%b",
             step_no, r, d, mr, ert, rs, rt, br, pc_write, if_id_write, if_flush, id_ex_bubble,
             stall, err);
    @(posedge clk);
    if (!r) begin
      if (e.stall) m_scnt = m_scnt + 32'd1;
      if (e.flush) m_fcnt = m_fcnt + 32'd1;
      if (m_wait == TO) m_err = 1'b1;
      case (m_state)
        0, 2: begin
          if (d) begin m_state = 1; m_wait = 0; end
          else m_state = 0;
        end
        default: begin
          if (d) begin
            if (m_wait < TO) m_wait = m_wait + 1;
          end else begin
            m_state = 2;
          end
        end
      endcase
    end
    step_no++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dcache_stall = 1'b0; mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    // reset state
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    // reset in the middle of a memory stall
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    // load-use on Rs, then cleared; Rt=0 never hazards; hazard through Rt
    step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0);
    // taken branch, no hazards
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle();
    // branch held across a 4-cycle d-cache stall flushes once in RELEASE
    repeat (4) step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle();
    // load-use under a stall: stall wins, bubble follows once the stall drops
    repeat (2) step(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    idle();
    // mixed traffic
    for (int i = 0; i < 40; i++) begin
      step(1'b0, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end
    idle();
    // stuck memory: err rises and stays set until reset
    repeat (20) step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check_val("err_sticky", {31'd0, err}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) idle();
    check_val("err_cleared", {31'd0, err}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
